gx_reset_seq: RTL
=================

# gx_reset_seq

Per-channel transceiver reset sequencer for the Cyclone 10 GX native PHY. It drives the analog and digital reset inputs of one channel group in the required order and releases them only once calibration has finished, the TX PLL is locked, and the RX CDR has held lock to data. It sits inside `top_pcs` between the transceiver status outputs and the PCS datapath. `tx_ready_o` and `rx_ready_o` gate the PCS TX and RX logic.

## Interface
- `T_ANALOG_CYC`, default 4: minimum number of cycles analog reset is held (≥70 ns at 50 MHz).
- `T_DIG_CYC`, default 4: consecutive cycles of `pll_locked && !tx_cal_busy` required before TX digital reset is released.
- `T_LTD_CYC`, default 200: consecutive cycles of lock-to-data required before RX digital reset is released (4 µs at 50 MHz).
- `T_LTD_TIMEOUT`, default 25000: cycles allowed in RX_LTD before the RX path restarts from analog reset.
- `clk` in 1: free-running management clock (`clk_50m`).
- `nreset` in 1: reset, asynchronous assert, active-low. Deassertion is already synchronised by the parent.
- `pll_locked_i` in 1: TX fPLL locked. Asynchronous input.
- `tx_cal_busy_i` in 1: TX calibration in progress. Asynchronous input.
- `rx_cal_busy_i` in 1: RX calibration in progress. Asynchronous input.
- `rx_is_lockedtodata_i` in 1: CDR locked to data. Asynchronous input.
- `tx_analogreset_o` out 1: TX PMA reset, active-high.
- `tx_digitalreset_o` out 1: TX PCS reset, active-high.
- `rx_analogreset_o` out 1: RX PMA reset, active-high.
- `rx_digitalreset_o` out 1: RX PCS reset, active-high.
- `tx_ready_o` out 1: TX path usable.
- `rx_ready_o` out 1: RX path usable.

## Operation
- **Input synchronisation**
  - All four status inputs pass through a 2-flop synchroniser, giving `s_pll`, `s_txcal`, `s_rxcal` and `s_ltd`.
  - FSM decisions use the synchronised signals only.
- **Counters and outputs**
  - TX and RX paths are independent FSMs, each with its own counter.
  - Counter width is `$clog2` of the largest parameter it must reach, plus 1. Counters saturate and never wrap.
  - Outputs are flops, updated on the same edge as the state register. They are not combinational decodes.
- **TX FSM**
  - TX_ANA: analog=1, digital=1, ready=0. `cnt` increments. Exit to TX_DIG when `cnt ≥ T_ANALOG_CYC-1 && !s_txcal`; `cnt` is cleared on exit.
  - TX_DIG: analog=0, digital=1, ready=0. `cnt` increments while `s_pll && !s_txcal`, otherwise clears to 0. Exit to TX_READY when `cnt == T_DIG_CYC-1` and the condition still holds.
  - TX_READY: analog=0, digital=0, ready=1.
  - From TX_DIG or TX_READY: `s_txcal` high → TX_ANA. This has highest priority.
  - From TX_READY: `!s_pll` → TX_DIG.
- **RX FSM**
  - RX_ANA: analog=1, digital=1, ready=0. Same exit rule as TX_ANA, using `s_rxcal`.
  - RX_LTD: analog=0, digital=1, ready=0.
    - Stability counter `scnt` increments while `s_ltd`, otherwise clears.
    - Timeout counter `tcnt` increments every cycle.
    - `scnt == T_LTD_CYC-1 && s_ltd` → RX_READY.
    - Otherwise, `tcnt == T_LTD_TIMEOUT-1` → RX_ANA. Reaching lock wins over timeout when both occur in the same cycle.
  - RX_READY: analog=0, digital=0, ready=1.
  - From RX_LTD or RX_READY: `s_rxcal` high → RX_ANA. This has highest priority.
  - From RX_READY: `!s_ltd` → RX_LTD. Digital reset reasserts; both counters clear.
- **Reset**
  - Asserting `nreset` at any time, including mid-sequence, forces TX_ANA and RX_ANA and clears all counters and synchroniser flops.
  - Reset output values: all four `*reset_o` = 1, `tx_ready_o` = 0, `rx_ready_o` = 0.
- **Ordering invariants**
  - Digital reset is never released while analog reset is asserted.
  - `ready` is high only when both resets of its path are low.

## Timing
- Input-to-decision latency is 2 cycles (synchroniser). The output changes on the following edge, so status-to-output latency is 3 cycles.
- With inputs already quiet (`cal_busy`=0, `pll`=1, `ltd`=1) at `nreset` release, counting from the first edge after release:
  - analog resets fall after `T_ANALOG_CYC` cycles;
  - `tx_digitalreset_o` falls `T_DIG_CYC` cycles after `tx_analogreset_o` falls;
  - `rx_digitalreset_o` falls `T_LTD_CYC` cycles after `rx_analogreset_o` falls.
- A one-cycle glitch on `s_ltd` in RX_LTD restarts the full `T_LTD_CYC` window. In RX_READY the same glitch forces RX_LTD.

## Test plan
All scenarios use `T_ANALOG_CYC`=4, `T_DIG_CYC`=4, `T_LTD_CYC`=8, `T_LTD_TIMEOUT`=64.

- **Clean bring-up.** Inputs quiet; release `nreset`.
  - Analog resets fall at cycle 4.
  - `tx_digitalreset_o` falls and `tx_ready_o` rises at cycle 8.
  - `rx_digitalreset_o` falls and `rx_ready_o` rises at cycle 12.
- **Cal busy holds analog.** `tx_cal_busy_i`=1 until cycle 20.
  - `tx_analogreset_o` stays 1 until cycle 23 (20 + 2 sync + 1).
  - The RX path is unaffected.
- **Lock glitch.** In RX_LTD, drop `rx_is_lockedtodata_i` for 1 cycle at `scnt`=5.
  - RX ready is delayed by a full 8-cycle window measured from the glitch's synchronised recovery.
- **Lock loss in ready.** In RX_READY, drop lock.
  - `rx_digitalreset_o`=1 and `rx_ready_o`=0 three cycles later.
  - `rx_analogreset_o` stays 0.
  - Restoring lock gives ready again 8 cycles after the synchronised recovery.
- **Timeout.** Hold lock low in RX_LTD for more than 64 cycles.
  - At cycle 64 of RX_LTD, `rx_analogreset_o` returns to 1.
  - The sequence then restarts from RX_ANA.
- **Reset mid-operation.** Assert `nreset` while in TX_READY/RX_READY.
  - All resets go to 1 and both ready outputs go to 0 asynchronously.
  - On release, the clean bring-up timing repeats exactly.

Source files
------------

// File: rtl/gx_reset_seq_if.sv
// Status and reset bundle between the reset sequencer and one transceiver
// channel group. The sequencer (master) consumes the PHY status signals and
// drives the reset/ready outputs; the PHY side (slave) does the opposite.
interface gx_reset_seq_if;
  logic pll_locked_i;
  logic tx_cal_busy_i;
  logic rx_cal_busy_i;
  logic rx_is_lockedtodata_i;
  logic tx_analogreset_o;
  logic tx_digitalreset_o;
  logic rx_analogreset_o;
  logic rx_digitalreset_o;
  logic tx_ready_o;
  logic rx_ready_o;

  modport master (
    input  pll_locked_i,
    input  tx_cal_busy_i,
    input  rx_cal_busy_i,
    input  rx_is_lockedtodata_i,
    output tx_analogreset_o,
    output tx_digitalreset_o,
    output rx_analogreset_o,
    output rx_digitalreset_o,
    output tx_ready_o,
    output rx_ready_o
  );

  modport slave (
    output pll_locked_i,
    output tx_cal_busy_i,
    output rx_cal_busy_i,
    output rx_is_lockedtodata_i,
    input  tx_analogreset_o,
    input  tx_digitalreset_o,
    input  rx_analogreset_o,
    input  rx_digitalreset_o,
    input  tx_ready_o,
    input  rx_ready_o
  );
endinterface

// File: rtl/gx_reset_seq.sv
// Per-channel transceiver reset sequencer. Holds analog reset for a minimum
// time, then releases TX digital reset once the PLL is locked and RX digital
// reset once the CDR has held lock to data for a full stability window.
// TX and RX run as independent FSMs; all outputs are registered.
module gx_reset_seq #(
  parameter int T_ANALOG_CYC  = 4,
  parameter int T_DIG_CYC     = 4,
  parameter int T_LTD_CYC     = 200,
  parameter int T_LTD_TIMEOUT = 25000
) (
  input  logic          clk,
  input  logic          nreset,
  gx_reset_seq_if.master phy
);

  localparam int TX_MAX = (T_ANALOG_CYC > T_DIG_CYC) ? T_ANALOG_CYC : T_DIG_CYC;
  localparam int RX_MAX = (T_ANALOG_CYC > T_LTD_CYC) ? T_ANALOG_CYC : T_LTD_CYC;
  localparam int TX_CW  = $clog2(TX_MAX) + 1;
  localparam int RX_CW  = $clog2(RX_MAX) + 1;
  localparam int TO_CW  = $clog2(T_LTD_TIMEOUT) + 1;

  localparam logic [TX_CW-1:0] TX_ANA_LAST = TX_CW'(T_ANALOG_CYC - 1);
  localparam logic [TX_CW-1:0] TX_DIG_LAST = TX_CW'(T_DIG_CYC - 1);
  localparam logic [RX_CW-1:0] RX_ANA_LAST = RX_CW'(T_ANALOG_CYC - 1);
  localparam logic [RX_CW-1:0] RX_LTD_LAST = RX_CW'(T_LTD_CYC - 1);
  localparam logic [TO_CW-1:0] RX_TO_LAST  = TO_CW'(T_LTD_TIMEOUT - 1);

  typedef enum logic [1:0] {TX_ANA, TX_DIG, TX_READY} tx_state_e;
  typedef enum logic [1:0] {RX_ANA, RX_LTD, RX_READY} rx_state_e;

  // Saturating increments: counters park at all-ones instead of wrapping.
  function automatic logic [TX_CW-1:0] tx_sat_inc(input logic [TX_CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [RX_CW-1:0] rx_sat_inc(input logic [RX_CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [TO_CW-1:0] to_sat_inc(input logic [TO_CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [3:0] sync_p0;
  logic [3:0] sync_p1;
  logic       s_pll, s_txcal, s_rxcal, s_ltd;

  tx_state_e        tx_state_q, tx_state_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic             tx_ana_q, tx_dig_q, tx_rdy_q;
  logic             tx_ana_d, tx_dig_d, tx_rdy_d;

  rx_state_e        rx_state_q, rx_state_d;
  logic [RX_CW-1:0] rx_scnt_q, rx_scnt_d;
  logic [TO_CW-1:0] rx_tcnt_q, rx_tcnt_d;
  logic             rx_ana_q, rx_dig_q, rx_rdy_q;
  logic             rx_ana_d, rx_dig_d, rx_rdy_d;

  // Two-flop synchroniser for the asynchronous PHY status inputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {phy.rx_is_lockedtodata_i, phy.rx_cal_busy_i,
                  phy.tx_cal_busy_i, phy.pll_locked_i};
      sync_p1 <= sync_p0;
    end
  end

  assign s_pll   = sync_p1[0];
  assign s_txcal = sync_p1[1];
  assign s_rxcal = sync_p1[2];
  assign s_ltd   = sync_p1[3];

  // TX next state, counter and registered-output decode.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    case (tx_state_q)
      TX_ANA: begin
        tx_cnt_d = tx_sat_inc(tx_cnt_q);
        if (tx_cnt_q >= TX_ANA_LAST && !s_txcal) begin
          tx_state_d = TX_DIG;
          tx_cnt_d   = '0;
        end
      end
      TX_DIG: begin
        if (s_txcal) begin
          tx_state_d = TX_ANA;
          tx_cnt_d   = '0;
        end else if (s_pll) begin
          if (tx_cnt_q == TX_DIG_LAST) begin
            tx_state_d = TX_READY;
            tx_cnt_d   = '0;
          end else begin
            tx_cnt_d = tx_sat_inc(tx_cnt_q);
          end
        end else begin
          tx_cnt_d = '0;
        end
      end
      TX_READY: begin
        if (s_txcal) begin
          tx_state_d = TX_ANA;
          tx_cnt_d   = '0;
        end else if (!s_pll) begin
          tx_state_d = TX_DIG;
          tx_cnt_d   = '0;
        end
      end
      default: begin
        tx_state_d = TX_ANA;
        tx_cnt_d   = '0;
      end
    endcase
    tx_ana_d = (tx_state_d == TX_ANA);
    tx_dig_d = (tx_state_d != TX_READY);
    tx_rdy_d = (tx_state_d == TX_READY);
  end

  // RX next state, stability/timeout counters and registered-output decode.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_scnt_d  = rx_scnt_q;
    rx_tcnt_d  = rx_tcnt_q;
    case (rx_state_q)
      RX_ANA: begin
        rx_scnt_d = rx_sat_inc(rx_scnt_q);
        if (rx_scnt_q >= RX_ANA_LAST && !s_rxcal) begin
          rx_state_d = RX_LTD;
          rx_scnt_d  = '0;
          rx_tcnt_d  = '0;
        end
      end
      RX_LTD: begin
        if (s_rxcal) begin
          rx_state_d = RX_ANA;
          rx_scnt_d  = '0;
          rx_tcnt_d  = '0;
        end else if (s_ltd && rx_scnt_q == RX_LTD_LAST) begin
          rx_state_d = RX_READY;
          rx_scnt_d  = '0;
          rx_tcnt_d  = '0;
        end else if (rx_tcnt_q == RX_TO_LAST) begin
          rx_state_d = RX_ANA;
          rx_scnt_d  = '0;
          rx_tcnt_d  = '0;
        end else begin
          rx_scnt_d = s_ltd ? rx_sat_inc(rx_scnt_q) : '0;
          rx_tcnt_d = to_sat_inc(rx_tcnt_q);
        end
      end
      RX_READY: begin
        if (s_rxcal) begin
          rx_state_d = RX_ANA;
          rx_scnt_d  = '0;
          rx_tcnt_d  = '0;
        end else if (!s_ltd) begin
          rx_state_d = RX_LTD;
          rx_scnt_d  = '0;
          rx_tcnt_d  = '0;
        end
      end
      default: begin
        rx_state_d = RX_ANA;
        rx_scnt_d  = '0;
        rx_tcnt_d  = '0;
      end
    endcase
    rx_ana_d = (rx_state_d == RX_ANA);
    rx_dig_d = (rx_state_d != RX_READY);
    rx_rdy_d = (rx_state_d == RX_READY);
  end

  // State, counter and output registers; reset holds every PHY block in reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_state_q <= TX_ANA;
      tx_cnt_q   <= '0;
      tx_ana_q   <= 1'b1;
      tx_dig_q   <= 1'b1;
      tx_rdy_q   <= 1'b0;
      rx_state_q <= RX_ANA;
      rx_scnt_q  <= '0;
      rx_tcnt_q  <= '0;
      rx_ana_q   <= 1'b1;
      rx_dig_q   <= 1'b1;
      rx_rdy_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_ana_q   <= tx_ana_d;
      tx_dig_q   <= tx_dig_d;
      tx_rdy_q   <= tx_rdy_d;
      rx_state_q <= rx_state_d;
      rx_scnt_q  <= rx_scnt_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_ana_q   <= rx_ana_d;
      rx_dig_q   <= rx_dig_d;
      rx_rdy_q   <= rx_rdy_d;
    end
  end

  assign phy.tx_analogreset_o  = tx_ana_q;
  assign phy.tx_digitalreset_o = tx_dig_q;
  assign phy.tx_ready_o        = tx_rdy_q;
  assign phy.rx_analogreset_o  = rx_ana_q;
  assign phy.rx_digitalreset_o = rx_dig_q;
  assign phy.rx_ready_o        = rx_rdy_q;

endmodule
